// File: rtl/mem_arbiter.sv
// Shares one word-addressed byte-lane RAM between instruction fetch and the LSU.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the LSU wins ties.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH:0]   i_if_addr,
  output logic                  o_if_ready,
  output logic                  o_if_rvalid,
  output logic [DATA_WIDTH:0]   o_if_rdata,
  input  logic                  i_ls_req,
  input  logic                  i_ls_we,
  input  logic [2:0]            i_ls_funct3,
  input  logic [ADDR_WIDTH:0]   i_ls_addr,
  input  logic [DATA_WIDTH:0]   i_ls_wdata,
  output logic                  o_ls_ready,
  output logic                  o_ls_rvalid,
  output logic [DATA_WIDTH:0]   o_ls_rdata,
  output logic                  o_ls_err,
  output logic                  o_ram_read_req,
  output logic [ADDR_WIDTH:0]   o_ram_read_addr,
  input  logic [DATA_WIDTH:0]   i_ram_read_data,
  output logic                  o_ram_write_enable,
  output logic [3:0]            o_ram_byte_enable,
  output logic [ADDR_WIDTH:0]   o_ram_write_addr,
  output logic [DATA_WIDTH:0]   o_ram_write_data
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP} state_t;

  state_t             state, state_next;
  logic               rd_is_ls;
  logic [2:0]         rd_funct3;
  logic [1:0]         rd_off;

  logic               idle_open, ls_win, if_win;
  logic               ls_acc, if_acc, ls_rd, ls_wr, ls_bad, rd_accept;
  logic               ls_legal;
  logic [3:0]         be;
  logic [DATA_WIDTH:0] wrep;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [DATA_WIDTH:0] ld_fmt;
  logic               unused_if_offset;

  assign unused_if_offset = ^i_if_addr[1:0];

  // Readies and strobes are forced low during reset and while stalled.
  assign idle_open = rst_n & clk_en & (state == IDLE);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_ls;
  assign ls_win = i_ls_req & (~i_if_req | ~last_ls);
`else
  assign ls_win = i_ls_req;
`endif
  assign if_win = i_if_req & ~ls_win;

  assign o_ls_ready = idle_open & ls_win;
  assign o_if_ready = idle_open & if_win;
  assign ls_acc     = o_ls_ready;
  assign if_acc     = o_if_ready;

  always_comb begin
    ls_legal = 1'b0;
    be       = '0;
    wrep     = '0;
    case (i_ls_funct3)
      3'b000: begin
        ls_legal = 1'b1;
        be       = 4'b0001 << i_ls_addr[1:0];
        wrep     = {4{i_ls_wdata[7:0]}};
      end
      3'b001: begin
        ls_legal = ~i_ls_addr[0];
        be       = i_ls_addr[1] ? 4'b1100 : 4'b0011;
        wrep     = {2{i_ls_wdata[15:0]}};
      end
      3'b010: begin
        ls_legal = (i_ls_addr[1:0] == 2'b00);
        be       = '1;
        wrep     = i_ls_wdata;
      end
      3'b100:  ls_legal = ~i_ls_we;
      3'b101:  ls_legal = ~i_ls_we & ~i_ls_addr[0];
      default: ls_legal = 1'b0;
    endcase
  end

  assign ls_rd     = ls_acc & ls_legal & ~i_ls_we;
  assign ls_wr     = ls_acc & ls_legal & i_ls_we;
  assign ls_bad    = ls_acc & ~ls_legal;
  assign rd_accept = ls_rd | if_acc;

  assign o_ram_read_req     = rd_accept;
  assign o_ram_read_addr    = ls_rd  ? {2'b00, i_ls_addr[ADDR_WIDTH:2]} :
                              if_acc ? {2'b00, i_if_addr[ADDR_WIDTH:2]} : '0;
  assign o_ram_write_enable = ls_wr;
  assign o_ram_byte_enable  = ls_wr ? be : '0;
  assign o_ram_write_addr   = ls_wr ? {2'b00, i_ls_addr[ADDR_WIDTH:2]} : '0;
  assign o_ram_write_data   = ls_wr ? wrep : '0;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rd_accept) state_next = RD_WAIT;
      RD_WAIT: state_next = RD_RESP;
      RD_RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (rd_off)
      2'd0:    rd_byte = i_ram_read_data[7:0];
      2'd1:    rd_byte = i_ram_read_data[15:8];
      2'd2:    rd_byte = i_ram_read_data[23:16];
      default: rd_byte = i_ram_read_data[31:24];
    endcase
    rd_half = rd_off[1] ? i_ram_read_data[31:16] : i_ram_read_data[15:0];
    case (rd_funct3)
      3'b000:  ld_fmt = {{(DATA_WIDTH-7){rd_byte[7]}}, rd_byte};
      3'b001:  ld_fmt = {{(DATA_WIDTH-15){rd_half[15]}}, rd_half};
      3'b100:  ld_fmt = {{(DATA_WIDTH-7){1'b0}}, rd_byte};
      3'b101:  ld_fmt = {{(DATA_WIDTH-15){1'b0}}, rd_half};
      default: ld_fmt = i_ram_read_data;
    endcase
  end

  // Response registers only advance on enabled cycles, which stretches rvalid over stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_is_ls    <= 1'b0;
      rd_funct3   <= '0;
      rd_off      <= '0;
      o_if_rvalid <= 1'b0;
      o_if_rdata  <= '0;
      o_ls_rvalid <= 1'b0;
      o_ls_rdata  <= '0;
      o_ls_err    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_ls     <= 1'b0;
`endif
    end else if (clk_en) begin
      state       <= state_next;
      o_if_rvalid <= 1'b0;
      o_ls_rvalid <= 1'b0;
      o_ls_err    <= 1'b0;
      if (rd_accept) begin
        rd_is_ls  <= ls_rd;
        rd_funct3 <= ls_rd ? i_ls_funct3 : 3'b010;
        rd_off    <= ls_rd ? i_ls_addr[1:0] : 2'b00;
      end
      if (ls_wr) begin
        o_ls_rvalid <= 1'b1;
        o_ls_rdata  <= '0;
      end
      if (ls_bad) begin
        o_ls_rvalid <= 1'b1;
        o_ls_err    <= 1'b1;
        o_ls_rdata  <= '0;
      end
      if (state == RD_WAIT) begin
        if (rd_is_ls) begin
          o_ls_rvalid <= 1'b1;
          o_ls_rdata  <= ld_fmt;
        end else begin
          o_if_rvalid <= 1'b1;
          o_if_rdata  <= i_ram_read_data;
        end
      end
`ifdef ARB_ROUND_ROBIN_EN
      if (ls_acc)      last_ls <= 1'b1;
      else if (if_acc) last_ls <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-lane data RAM (4 x 8-bit lanes, word-addressed, 1-cycle registered read) between the instruction-fetch unit and the load/store unit of the RV32I core.
- Arbitrates requests and sequences the RAM read latency.
- Generates byte enables and lane-replicated write data for SB/SH/SW.
- Aligns and sign- or zero-extends load data. Rejects misaligned or illegal LSU accesses with an error response.

Parameters:
- ADDR_WIDTH, 31: MSB index of the byte-address buses. The RAM word address is addr[ADDR_WIDTH:2], zero-extended to ADDR_WIDTH+1 bits.
- DATA_WIDTH, 31: MSB index of the data buses. Fixed at 31; other values are unsupported.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  global stall qualifier. When low, all state is frozen and all RAM strobes are 0.
- i_if_req  in  1  fetch request.
- i_if_addr  in  ADDR_WIDTH+1  fetch byte address. Bits [1:0] are ignored.
- o_if_ready  out  1  fetch request accepted this cycle.
- o_if_rvalid  out  1  fetch data valid, 1-cycle pulse.
- o_if_rdata  out  DATA_WIDTH+1  fetched word.
- i_ls_req  in  1  LSU request.
- i_ls_we  in  1  1 = store, 0 = load.
- i_ls_funct3  in  3  RV32I funct3 width/sign code.
- i_ls_addr  in  ADDR_WIDTH+1  LSU byte address.
- i_ls_wdata  in  DATA_WIDTH+1  store data, right-aligned.
- o_ls_ready  out  1  LSU request accepted this cycle.
- o_ls_rvalid  out  1  load data / store acknowledge / error, 1-cycle pulse.
- o_ls_rdata  out  DATA_WIDTH+1  formatted load data. 0 for stores and errors.
- o_ls_err  out  1  misaligned or illegal access. Qualified by o_ls_rvalid.
- o_ram_read_req  out  1  RAM read strobe.
- o_ram_read_addr  out  ADDR_WIDTH+1  RAM word address.
- i_ram_read_data  in  DATA_WIDTH+1  RAM read data. Valid the cycle after o_ram_read_req.
- o_ram_write_enable  out  1  RAM write strobe.
- o_ram_byte_enable  out  4  lane enables; bit0 = bits [7:0].
- o_ram_write_addr  out  ADDR_WIDTH+1  RAM word address.
- o_ram_write_data  out  DATA_WIDTH+1  lane-replicated store data.

Behaviour:
- Reset: async on rst_n low. FSM goes to IDLE. All registered outputs (rvalid, rdata, err) are 0. last_grant = IF. Combinational outputs are 0 while in reset. An in-flight read is discarded and no response is ever issued for it.
- FSM states: IDLE, RD_WAIT, RD_RESP. Transitions occur only when clk_en = 1.
- IDLE:
  - o_*_ready is asserted combinationally, in the same cycle, for the arbitration winner only. Accept = req & ready & clk_en.
  - Accepted legal load or fetch: o_ram_read_req = 1 with the word address in the same cycle; next state RD_WAIT. The requester identity is latched.
  - Accepted legal store: o_ram_write_enable = 1 with the byte enables and data in the same cycle. FSM stays in IDLE. o_ls_rvalid pulses the next cycle with err = 0. Back-to-back stores sustain 1 per cycle.
  - Accepted illegal LSU access: no RAM strobe. The next cycle gives o_ls_rvalid = 1, o_ls_err = 1, rdata = 0. FSM stays in IDLE.
- RD_WAIT: i_ram_read_data is valid. The formatted result is registered into o_if_rdata or o_ls_rdata; next state RD_RESP.
- RD_RESP: the requester's rvalid = 1 for one cycle; next state IDLE. Total latency is 2 cycles from accept edge to rvalid high. No accepts occur in RD_WAIT or RD_RESP (both readies = 0).
- Legality:
  - Loads accept funct3 000/001/010/100/101.
  - Stores accept funct3 000/001/010.
  - Everything else is illegal.
  - Halfword requires addr[0] = 0; word requires addr[1:0] = 0.
- Store lanes:
  - SB: enable = 1 << addr[1:0], data = {4{wdata[7:0]}}.
  - SH: enable = 0011 if addr[1] = 0, else 1100; data = {2{wdata[15:0]}}.
  - SW: enable = 1111, data = wdata.
- Load format: select the lane(s) by the latched addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Fetch is always a full word.
- Simultaneous IF and LSU requests in IDLE are resolved per the arbitration rule (see Optional Feature); the loser's ready stays 0 and its request must be held.
- clk_en low: FSM, last_grant and response registers hold their values. Readies and all RAM strobes are 0. An rvalid pulse is extended until the first clk_en-high cycle.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on a tie, the winner is the requester not named by last_grant. last_grant updates on every accept.
- Undefined: the LSU always wins ties (fixed priority) and last_grant is unused.

Test Plan:
- SW addr 0x10 data 0xA1B2C3D4, then LW 0x10 -> byte_enable 1111, write addr 0x4; LW rvalid 2 cycles after accept, rdata 0xA1B2C3D4.
- SB 0x13 data 0x85, then LB 0x13 and LBU 0x13 -> enable 1000, write_data 0x85858585; LB = 0xFFFFFF85, LBU = 0x00000085.
- LH 0x11 and SW 0x12 -> no RAM strobes; o_ls_rvalid & o_ls_err next cycle, rdata 0. An access with funct3 011 gets the same error response.
- IF and LSU both request every cycle from reset -> with ARB_ROUND_ROBIN_EN grants alternate LSU, IF, LSU...; without it the LSU always wins.
- IF read accepted, then rst_n pulsed low in RD_WAIT -> no o_if_rvalid; FSM in IDLE and both readies available after reset release.
- LW accepted, then clk_en low for 3 cycles in RD_WAIT -> state frozen, no strobes; rvalid appears 1 cycle after clk_en returns, with correct data.
